// File: rtl/defuse_sequencer_if.sv
// Board-side bundle for the defuse game controller.
// Inputs to the sequencer: 1 Hz tick, debounced active-high buttons, switch code.
// Outputs from the sequencer: level/key/time/strike status, outcome flags, LEDs.
//   master : board / stimulus side (drives tick, buttons, switches)
//   slave  : sequencer side (drives status and LEDs)
interface defuse_sequencer_if;
    logic        tick;
    logic        start_btn;
    logic        enter_btn;
    logic [17:0] sw;

    logic [2:0]  level;
    logic [17:0] level_key;
    logic [7:0]  time_left;
    logic [1:0]  strikes;
    logic        playing;
    logic        game_won;
    logic        game_over;
    logic [17:0] ledr;
    logic [7:0]  ledg;

    modport master (
        output tick, start_btn, enter_btn, sw,
        input  level, level_key, time_left, strikes,
               playing, game_won, game_over, ledr, ledg
    );

    modport slave (
        input  tick, start_btn, enter_btn, sw,
        output level, level_key, time_left, strikes,
               playing, game_won, game_over, ledr, ledg
    );
endinterface

// File: rtl/defuse_sequencer.sv
// Registered game controller for the defuse board: sequences up to four
// code-entry levels, runs the per-level countdown, counts strikes and holds
// the win/loss outcome.
// Ports:
//   clock  - system clock, the only clock
//   reset  - synchronous, active-high reset
//   bus    - defuse_sequencer_if.slave: tick/buttons/switches in,
//            level, level_key, time_left, strikes, playing, game_won,
//            game_over, ledr, ledg out (all registered)
module defuse_sequencer #(
    parameter int unsigned NUM_LEVELS  = 4,
    parameter int unsigned MAX_STRIKES = 3,
    parameter logic [7:0]  TIME_L1     = 8'd30,
    parameter logic [7:0]  TIME_L2     = 8'd20,
    parameter logic [7:0]  TIME_L3     = 8'd10,
    parameter logic [7:0]  TIME_L4     = 8'd5,
    parameter logic [17:0] KEY_L1      = 18'b000000000000011111,
    parameter logic [17:0] KEY_L2      = 18'b101010101010101010,
    parameter logic [17:0] KEY_L3      = 18'b110000110100101110,
    parameter logic [17:0] KEY_L4      = 18'b111111111110111111
) (
    input logic               clock,
    input logic               reset,
    defuse_sequencer_if.slave bus
);

    localparam int unsigned KEY_W  = 18;
    localparam int unsigned TIME_W = 8;
    localparam int unsigned LVL_W  = 3;
    localparam int unsigned STK_W  = 2;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_INTER,
        S_WON,
        S_LOST
    } state_e;

    state_e              state_q, state_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [TIME_W-1:0]   time_left_q, time_left_d;
    logic [STK_W-1:0]    strikes_q, strikes_d;
    logic [MASK_W-1:0]   cleared_q, cleared_d;
    logic                start_q, enter_q;
    logic [KEY_W-1:0]    level_key_q, level_key_d;
    logic                playing_q, playing_d;
    logic                game_won_q, game_won_d;
    logic                game_over_q, game_over_d;
    logic [KEY_W-1:0]    ledr_q, ledr_d;
    logic [7:0]          ledg_q, ledg_d;

    logic                start_p;
    logic                enter_p;
    logic [1:0]          lvl_idx;

    // Key lookup for a level number; 0 outside 1..4.
    function automatic logic [KEY_W-1:0] key_for(input logic [LVL_W-1:0] lvl);
        case (lvl)
            3'd1:    key_for = KEY_L1;
            3'd2:    key_for = KEY_L2;
            3'd3:    key_for = KEY_L3;
            3'd4:    key_for = KEY_L4;
            default: key_for = '0;
        endcase
    endfunction

    // Countdown start value for a level number.
    function automatic logic [TIME_W-1:0] time_for(input logic [LVL_W-1:0] lvl);
        case (lvl)
            3'd1:    time_for = TIME_L1;
            3'd2:    time_for = TIME_L2;
            3'd3:    time_for = TIME_L3;
            3'd4:    time_for = TIME_L4;
            default: time_for = '0;
        endcase
    endfunction

    // Rising-edge detect against last cycle's button sample.
    assign start_p = bus.start_btn & ~start_q;
    assign enter_p = bus.enter_btn & ~enter_q;
    assign lvl_idx = 2'(level_q - 3'd1);

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        time_left_d = time_left_q;
        strikes_d   = strikes_q;
        cleared_d   = cleared_q;

        case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    level_d   = 3'd1;
                    strikes_d = '0;
                    cleared_d = '0;
                    state_d   = S_LOAD;
                end
            end

            S_LOAD: begin
                time_left_d = time_for(level_q);
                state_d     = S_PLAY;
            end

            S_PLAY: begin
                // level_key_q holds the current key for the whole PLAY stay.
                if (enter_p && (bus.sw == level_key_q)) begin
                    cleared_d[lvl_idx] = 1'b1;
                    state_d = (level_q == LVL_W'(NUM_LEVELS)) ? S_WON : S_INTER;
                end else begin
                    // Wrong entry and tick are independent; either may lose.
                    if (enter_p) begin
                        if ((3'(strikes_q) + 3'd1) >= 3'(MAX_STRIKES)) begin
                            strikes_d = STK_W'(MAX_STRIKES);
                            state_d   = S_LOST;
                        end else begin
                            strikes_d = strikes_q + 2'd1;
                        end
                    end
                    if (bus.tick) begin
                        if (time_left_q <= 8'd1) begin
                            time_left_d = '0;
                            state_d     = S_LOST;
                        end else begin
                            time_left_d = time_left_q - 8'd1;
                        end
                    end
                end
            end

            S_INTER: begin
                if (start_p && (level_q < LVL_W'(NUM_LEVELS))) begin
                    level_d = level_q + 3'd1;
                    state_d = S_LOAD;
                end
            end

            S_WON, S_LOST: begin
                if (start_p) begin
                    level_d     = '0;
                    time_left_d = '0;
                    strikes_d   = '0;
                    cleared_d   = '0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered, so they line up with state_q.
        level_key_d = (state_d == S_PLAY) ? key_for(level_d) : '0;
        playing_d   = (state_d == S_LOAD) || (state_d == S_PLAY);
        game_won_d  = (state_d == S_WON);
        game_over_d = (state_d == S_LOST);

        case (state_d)
            S_PLAY:  ledr_d = key_for(level_d);
            S_LOST:  ledr_d = '1;
            default: ledr_d = '0;
        endcase

        ledg_d = (state_d == S_WON) ? 8'hFF : {strikes_d, 2'b00, cleared_d};
    end

    // State, counters, button history and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            level_q     <= '0;
            time_left_q <= '0;
            strikes_q   <= '0;
            cleared_q   <= '0;
            start_q     <= 1'b1;
            enter_q     <= 1'b1;
            level_key_q <= '0;
            playing_q   <= 1'b0;
            game_won_q  <= 1'b0;
            game_over_q <= 1'b0;
            ledr_q      <= '0;
            ledg_q      <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            time_left_q <= time_left_d;
            strikes_q   <= strikes_d;
            cleared_q   <= cleared_d;
            start_q     <= bus.start_btn;
            enter_q     <= bus.enter_btn;
            level_key_q <= level_key_d;
            playing_q   <= playing_d;
            game_won_q  <= game_won_d;
            game_over_q <= game_over_d;
            ledr_q      <= ledr_d;
            ledg_q      <= ledg_d;
        end
    end

    assign bus.level     = level_q;
    assign bus.level_key = level_key_q;
    assign bus.time_left = time_left_q;
    assign bus.strikes   = strikes_q;
    assign bus.playing   = playing_q;
    assign bus.game_won  = game_won_q;
    assign bus.game_over = game_over_q;
    assign bus.ledr      = ledr_q;
    assign bus.ledg      = ledg_q;

endmodule
